dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Owns the single read port and single write port of the data memory (bsram). Shares them between four requesters: cpu, a debug/loader port (dbg), rect_copy_controller (rc) and button_controller (bc).
- Sequences ownership hand-over around the per-frame copy window, so no read is lost or misrouted at the boundary.
- Replaces the plain copy-select muxes in front of bsram.

Parameters:
- DATA_ADDR_WIDTH, 13, data memory address width.
- CNT_WIDTH, 16, width of the saturating diagnostic counters.

Ports:
- clk  in  1  system clock (25.2 MHz).
- resetn  in  1  asynchronous, active-low reset.
- copy_req  in  1  copy window request from brus16_controller (level).
- copy_active  out  1  rc/bc own memory (replaces old copy select).
- cpu_rd_req, cpu_rd_addr  in  1, DATA_ADDR_WIDTH  cpu read request and address.
- cpu_rd_gnt, cpu_rvalid  out  1, 1  cpu read grant and read-data valid.
- cpu_wr_req, cpu_wr_addr, cpu_wr_data  in  1, DATA_ADDR_WIDTH, 16  cpu write request, address, data.
- cpu_wr_gnt  out  1  cpu write grant.
- dbg_rd_req, dbg_rd_addr  in  1, DATA_ADDR_WIDTH  debug read request and address.
- dbg_rd_gnt, dbg_rvalid  out  1, 1  debug read grant and read-data valid.
- dbg_wr_req, dbg_wr_addr, dbg_wr_data  in  1, DATA_ADDR_WIDTH, 16  debug write request, address, data.
- dbg_wr_gnt  out  1  debug write grant.
- rc_rd_req, rc_rd_addr  in  1, DATA_ADDR_WIDTH  rect copy read request and address.
- rc_rvalid  out  1  rect copy read-data valid.
- bc_we, bc_addr, bc_data  in  1, DATA_ADDR_WIDTH, 16  button controller write.
- mem_rd_addr  out  DATA_ADDR_WIDTH  to bsram read address.
- mem_rd_data  in  16  from bsram read data.
- rdata  out  16  mem_rd_data broadcast to all requesters.
- mem_we, mem_wr_addr, mem_wr_data  out  1, DATA_ADDR_WIDTH, 16  to bsram write port.
- drop_cnt  out  CNT_WIDTH  bc writes dropped outside the copy window.
- conflict_cnt  out  CNT_WIDTH  cycles with cpu/dbg contention on either port.

Behaviour:
- Reset (async, resetn=0):
  - state=RUN; both round-robin pointers = cpu.
  - All gnt/rvalid/mem_we/copy_active = 0; mem addresses and data = 0; counters = 0.
- Grants are combinational from requests, state and registered pointers. mem_* buses are combinational muxes of the granted requester; all zero when nothing is granted.
- Read latency is 1 cycle. rd_owner is registered on each read grant. <owner>_rvalid=1 exactly one cycle after that owner's grant; rdata=mem_rd_data.
- Read and write ports are arbitrated independently, each with its own pointer.
- FSM states: RUN, DRAIN, COPY, RELEASE.
- RUN:
  - cpu/dbg compete per port. If one requests, it is granted.
  - If both request, the requester not favoured by the pointer loses; the pointer flips to the loser after the grant (strict alternation under contention); conflict_cnt +1.
  - rc_rd_req is ignored.
  - bc_we=1 is not written; drop_cnt +1.
  - copy_req=1 -> DRAIN.
- DRAIN (1 cycle):
  - No grants to anyone; an outstanding cpu/dbg read returns its rvalid this cycle.
  - copy_req=1 -> COPY; copy_req=0 -> RUN.
- COPY:
  - copy_active=1.
  - rc read granted every cycle rc_rd_req=1; rc has no gnt port and is always granted.
  - bc_we=1 writes unconditionally.
  - cpu/dbg gnt=0; their requests stay pending, and requesters hold addr/data until granted.
  - copy_req=0 -> RELEASE.
- RELEASE (1 cycle):
  - copy_active=0, no grants, final rc_rvalid delivered.
  - Next state RUN, even if copy_req=1 again (minimum 1 RUN cycle between windows).
- Same-address read and write in one cycle: no forwarding; returns old data (bsram read-first).
- Counters saturate at all-ones and never wrap.
- Pointers hold their value across COPY.
- resetn asserted mid-window drops copy_active and all grants immediately (async). Any in-flight rvalid is lost.

Test Plan:
- Reset: resetn=0 with all requests=1 -> every gnt/rvalid/mem_we=0, copy_active=0, counters=0. Release resetn in RUN: cpu_rd_gnt=1 first (pointer=cpu).
- Contention: cpu_rd_req and dbg_rd_req held 1 for 6 cycles, addrs 0x010/0x020 -> grants alternate cpu,dbg,cpu,...; mem_rd_addr alternates; rvalid follows each grant by 1 cycle; conflict_cnt=6.
- Window entry: cpu read of 0x005 granted in the cycle copy_req rises -> cpu_rvalid next cycle (DRAIN), then copy_active=1 the following cycle. rc_rd_addr 0x100 -> rc_rvalid 1 cycle later with mem content.
- Window body: bc_we=1, bc_addr=0x1F0, bc_data=0xABCD during COPY -> mem_we=1 with those values. Simultaneous cpu_wr_req -> cpu_wr_gnt=0 until RELEASE+1.
- Window exit and drops: copy_req falls -> one RELEASE cycle with last rc_rvalid, then RUN. bc_we pulsed 3 times in RUN -> no mem_we, drop_cnt=3.
- Saturation: CNT_WIDTH=4 override, 20 contention cycles -> conflict_cnt=15 and stays.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every requester and bsram-side signal of the data memory arbiter.
//   slave  : arbiter view (requests and mem_rd_data in; grants, rvalids,
//            bsram controls and counters out)
//   master : requester/memory view (the mirror image of slave)
// Requesters: cpu and dbg (rd/wr with gnt), rc (read only, no gnt),
// bc (write only, no gnt). rdata is one broadcast shared by all readers.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DATA_ADDR_WIDTH = 13,
    parameter int CNT_WIDTH       = 16
);
    logic                       copy_req;
    logic                       copy_active;

    logic                       cpu_rd_req;
    logic [DATA_ADDR_WIDTH-1:0] cpu_rd_addr;
    logic                       cpu_rd_gnt;
    logic                       cpu_rvalid;
    logic                       cpu_wr_req;
    logic [DATA_ADDR_WIDTH-1:0] cpu_wr_addr;
    logic [15:0]                cpu_wr_data;
    logic                       cpu_wr_gnt;

    logic                       dbg_rd_req;
    logic [DATA_ADDR_WIDTH-1:0] dbg_rd_addr;
    logic                       dbg_rd_gnt;
    logic                       dbg_rvalid;
    logic                       dbg_wr_req;
    logic [DATA_ADDR_WIDTH-1:0] dbg_wr_addr;
    logic [15:0]                dbg_wr_data;
    logic                       dbg_wr_gnt;

    logic                       rc_rd_req;
    logic [DATA_ADDR_WIDTH-1:0] rc_rd_addr;
    logic                       rc_rvalid;

    logic                       bc_we;
    logic [DATA_ADDR_WIDTH-1:0] bc_addr;
    logic [15:0]                bc_data;

    logic [DATA_ADDR_WIDTH-1:0] mem_rd_addr;
    logic [15:0]                mem_rd_data;
    logic [15:0]                rdata;
    logic                       mem_we;
    logic [DATA_ADDR_WIDTH-1:0] mem_wr_addr;
    logic [15:0]                mem_wr_data;

    logic [CNT_WIDTH-1:0]       drop_cnt;
    logic [CNT_WIDTH-1:0]       conflict_cnt;

    modport slave (
        input  copy_req,
        input  cpu_rd_req, cpu_rd_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        input  dbg_rd_req, dbg_rd_addr, dbg_wr_req, dbg_wr_addr, dbg_wr_data,
        input  rc_rd_req, rc_rd_addr,
        input  bc_we, bc_addr, bc_data,
        input  mem_rd_data,
        output copy_active,
        output cpu_rd_gnt, cpu_rvalid, cpu_wr_gnt,
        output dbg_rd_gnt, dbg_rvalid, dbg_wr_gnt,
        output rc_rvalid,
        output mem_rd_addr, rdata, mem_we, mem_wr_addr, mem_wr_data,
        output drop_cnt, conflict_cnt
    );

    modport master (
        output copy_req,
        output cpu_rd_req, cpu_rd_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        output dbg_rd_req, dbg_rd_addr, dbg_wr_req, dbg_wr_addr, dbg_wr_data,
        output rc_rd_req, rc_rd_addr,
        output bc_we, bc_addr, bc_data,
        output mem_rd_data,
        input  copy_active,
        input  cpu_rd_gnt, cpu_rvalid, cpu_wr_gnt,
        input  dbg_rd_gnt, dbg_rvalid, dbg_wr_gnt,
        input  rc_rvalid,
        input  mem_rd_addr, rdata, mem_we, mem_wr_addr, mem_wr_data,
        input  drop_cnt, conflict_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Owns the single read and single write port of the data bsram and shares
// them between cpu, dbg, rect_copy_controller (rc) and button_controller (bc).
// Outside the copy window cpu/dbg share each port round-robin; inside it
// rc owns the read port and bc the write port. DRAIN and RELEASE are one-cycle
// buffer states so the last read of one owner set returns before the other
// set takes over.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : dmem_arbiter_if.slave (requests, grants, rvalids, bsram side,
//            saturating drop/conflict counters)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_ADDR_WIDTH = 13,
    parameter int CNT_WIDTH       = 16
) (
    input logic           clk,
    input logic           resetn,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {RUN, DRAIN, COPY, RELEASE} state_t;

    state_t state, state_nxt;

    // Pointer value 0 favours cpu, 1 favours dbg.
    logic rd_ptr, wr_ptr;

    // Cleared asynchronously by reset and set on the first clock after it,
    // so grants drop the instant resetn falls and never race its release.
    logic armed;

    logic run, copy_win;
    logic cpu_rd_g, dbg_rd_g, rc_rd_g;
    logic cpu_wr_g, dbg_wr_g, bc_wr_g;
    logic rd_conflict, wr_conflict, bc_drop;

    // Registered read owner (one-hot): each rvalid is the owner's grant
    // delayed by the bsram read latency of one cycle.
    logic cpu_rv, dbg_rv, rc_rv;

    logic [CNT_WIDTH-1:0] drop_q, conflict_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (bus.copy_req) state_nxt = DRAIN;
            DRAIN:   state_nxt = bus.copy_req ? COPY : RUN;
            COPY:    if (!bus.copy_req) state_nxt = RELEASE;
            RELEASE: state_nxt = RUN;   // always at least one RUN cycle
            default: state_nxt = RUN;
        endcase
    end

    // ---------------- grants ----------------
    assign run      = armed && (state == RUN);
    assign copy_win = armed && (state == COPY);

    assign cpu_rd_g = run & bus.cpu_rd_req & (~bus.dbg_rd_req | ~rd_ptr);
    assign dbg_rd_g = run & bus.dbg_rd_req & (~bus.cpu_rd_req |  rd_ptr);
    assign rc_rd_g  = copy_win & bus.rc_rd_req;

    assign cpu_wr_g = run & bus.cpu_wr_req & (~bus.dbg_wr_req | ~wr_ptr);
    assign dbg_wr_g = run & bus.dbg_wr_req & (~bus.cpu_wr_req |  wr_ptr);
    assign bc_wr_g  = copy_win & bus.bc_we;

    assign rd_conflict = run & bus.cpu_rd_req & bus.dbg_rd_req;
    assign wr_conflict = run & bus.cpu_wr_req & bus.dbg_wr_req;
    assign bc_drop     = armed & bus.bc_we & (state != COPY);

    // ---------------- bsram muxes (zero when idle) ----------------
    always_comb begin
        bus.mem_rd_addr = '0;
        if (cpu_rd_g)      bus.mem_rd_addr = bus.cpu_rd_addr;
        else if (dbg_rd_g) bus.mem_rd_addr = bus.dbg_rd_addr;
        else if (rc_rd_g)  bus.mem_rd_addr = bus.rc_rd_addr;
    end

    always_comb begin
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        if (cpu_wr_g) begin
            bus.mem_wr_addr = bus.cpu_wr_addr;
            bus.mem_wr_data = bus.cpu_wr_data;
        end else if (dbg_wr_g) begin
            bus.mem_wr_addr = bus.dbg_wr_addr;
            bus.mem_wr_data = bus.dbg_wr_data;
        end else if (bc_wr_g) begin
            bus.mem_wr_addr = bus.bc_addr;
            bus.mem_wr_data = bus.bc_data;
        end
    end

    assign bus.mem_we      = cpu_wr_g | dbg_wr_g | bc_wr_g;
    assign bus.copy_active = (state == COPY);
    assign bus.cpu_rd_gnt  = cpu_rd_g;
    assign bus.dbg_rd_gnt  = dbg_rd_g;
    assign bus.cpu_wr_gnt  = cpu_wr_g;
    assign bus.dbg_wr_gnt  = dbg_wr_g;
    assign bus.cpu_rvalid  = cpu_rv;
    assign bus.dbg_rvalid  = dbg_rv;
    assign bus.rc_rvalid   = rc_rv;
    assign bus.rdata       = bus.mem_rd_data;
    assign bus.drop_cnt    = drop_q;
    assign bus.conflict_cnt = conflict_q;

    // ---------------- sequential state ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed      <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            cpu_rv     <= 1'b0;
            dbg_rv     <= 1'b0;
            rc_rv      <= 1'b0;
            drop_q     <= '0;
            conflict_q <= '0;
        end else begin
            armed  <= 1'b1;
            cpu_rv <= cpu_rd_g;
            dbg_rv <= dbg_rd_g;
            rc_rv  <= rc_rd_g;
            // Under contention the winner was the favoured side, so toggling
            // hands preference to the loser. Pointers only move in RUN.
            if (rd_conflict) rd_ptr <= ~rd_ptr;
            if (wr_conflict) wr_ptr <= ~wr_ptr;
            if ((rd_conflict | wr_conflict) && (conflict_q != '1))
                conflict_q <= conflict_q + CNT_WIDTH'(1);
            if (bc_drop && (drop_q != '1))
                drop_q <= drop_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. A read-first bsram model preloaded with
// 0xC000|addr answers the read port. A second instance with 4-bit counters
// covers counter saturation.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_ADDR_WIDTH(AW), .CNT_WIDTH(16)) bus ();
    dmem_arbiter_if #(.DATA_ADDR_WIDTH(AW), .CNT_WIDTH(4))  sbus ();

    dmem_arbiter #(.DATA_ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );
    dmem_arbiter #(.DATA_ADDR_WIDTH(AW), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .resetn(resetn), .bus(sbus)
    );

    // read-first bsram model
    logic [15:0] mem [0:8191];
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 16'hC000 | 16'(i);
            bus.mem_rd_data <= 16'h0;
        end else begin
            bus.mem_rd_data <= mem[bus.mem_rd_addr];
            if (bus.mem_we) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        end
    end
    assign sbus.mem_rd_data = 16'h0;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.copy_req = 0;
        bus.cpu_rd_req = 0; bus.cpu_rd_addr = '0;
        bus.cpu_wr_req = 0; bus.cpu_wr_addr = '0; bus.cpu_wr_data = '0;
        bus.dbg_rd_req = 0; bus.dbg_rd_addr = '0;
        bus.dbg_wr_req = 0; bus.dbg_wr_addr = '0; bus.dbg_wr_data = '0;
        bus.rc_rd_req = 0;  bus.rc_rd_addr = '0;
        bus.bc_we = 0;      bus.bc_addr = '0;     bus.bc_data = '0;
    endtask

    initial begin
        sbus.copy_req = 0;
        sbus.cpu_rd_req = 0; sbus.cpu_rd_addr = 13'h011;
        sbus.cpu_wr_req = 0; sbus.cpu_wr_addr = '0; sbus.cpu_wr_data = '0;
        sbus.dbg_rd_req = 0; sbus.dbg_rd_addr = 13'h022;
        sbus.dbg_wr_req = 0; sbus.dbg_wr_addr = '0; sbus.dbg_wr_data = '0;
        sbus.rc_rd_req = 0;  sbus.rc_rd_addr = '0;
        sbus.bc_we = 0;      sbus.bc_addr = '0;     sbus.bc_data = '0;

        // reset with every request asserted
        idle();
        bus.copy_req = 1;
        bus.cpu_rd_req = 1; bus.cpu_rd_addr = 13'h001;
        bus.cpu_wr_req = 1; bus.cpu_wr_addr = 13'h002; bus.cpu_wr_data = 16'h1;
        bus.dbg_rd_req = 1; bus.dbg_rd_addr = 13'h003;
        bus.dbg_wr_req = 1; bus.dbg_wr_addr = 13'h004; bus.dbg_wr_data = 16'h2;
        bus.rc_rd_req = 1;  bus.rc_rd_addr = 13'h005;
        bus.bc_we = 1;      bus.bc_addr = 13'h006;     bus.bc_data = 16'h3;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", {bus.cpu_rd_gnt, bus.dbg_rd_gnt, bus.cpu_wr_gnt, bus.dbg_wr_gnt}, 0);
        chk("rst_we_copy", {bus.mem_we, bus.copy_active}, 0);
        chk("rst_rvalid", {bus.cpu_rvalid, bus.dbg_rvalid, bus.rc_rvalid}, 0);
        chk("rst_mem_bus", {bus.mem_rd_addr, bus.mem_wr_addr}, 0);
        chk("rst_mem_wdata", bus.mem_wr_data, 0);
        chk("rst_cnt", {bus.drop_cnt, bus.conflict_cnt}, 0);

        // release reset, set up cpu/dbg read contention
        @(negedge clk);
        resetn = 1;
        idle();
        bus.cpu_rd_req = 1; bus.cpu_rd_addr = 13'h010;
        bus.dbg_rd_req = 1; bus.dbg_rd_addr = 13'h020;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("cont_cpu_gnt", bus.cpu_rd_gnt, (k % 2 == 0));
            chk("cont_dbg_gnt", bus.dbg_rd_gnt, (k % 2 == 1));
            chk("cont_rd_addr", bus.mem_rd_addr, (k % 2 == 0) ? 32'h010 : 32'h020);
            if (k > 0) begin
                chk("cont_cpu_rv", bus.cpu_rvalid, (k % 2 == 1));
                chk("cont_rdata", bus.rdata, (k % 2 == 1) ? 32'hC010 : 32'hC020);
            end
        end

        // last dbg rvalid, conflict count, solo cpu write
        @(negedge clk);
        idle();
        bus.cpu_wr_req = 1; bus.cpu_wr_addr = 13'h033; bus.cpu_wr_data = 16'h1234;
        #1;
        chk("cont_last_rv", {bus.cpu_rvalid, bus.dbg_rvalid}, 2'b01);
        chk("cont_last_rdata", bus.rdata, 16'hC020);
        chk("conflict_6", bus.conflict_cnt, 6);
        chk("cpu_wr_solo", {bus.cpu_wr_gnt, bus.mem_we}, 2'b11);
        chk("cpu_wr_bus", {bus.mem_wr_addr, bus.mem_wr_data}, {13'h033, 16'h1234});

        // write-port contention: independent pointer starts at cpu
        @(negedge clk);
        idle();
        bus.cpu_wr_req = 1; bus.cpu_wr_addr = 13'h040; bus.cpu_wr_data = 16'h1111;
        bus.dbg_wr_req = 1; bus.dbg_wr_addr = 13'h041; bus.dbg_wr_data = 16'h2222;
        #1;
        chk("wr_cont1_gnt", {bus.cpu_wr_gnt, bus.dbg_wr_gnt}, 2'b10);
        chk("wr_cont1_addr", bus.mem_wr_addr, 13'h040);
        @(negedge clk);
        #1;
        chk("wr_cont2_gnt", {bus.cpu_wr_gnt, bus.dbg_wr_gnt}, 2'b01);
        chk("wr_cont2_bus", {bus.mem_wr_addr, bus.mem_wr_data}, {13'h041, 16'h2222});
        chk("conflict_7", bus.conflict_cnt, 7);
        @(negedge clk);
        idle();
        #1;
        chk("conflict_8", bus.conflict_cnt, 8);

        // same-address read and write: old data comes back
        @(negedge clk);
        bus.cpu_rd_req = 1; bus.cpu_rd_addr = 13'h033;
        bus.dbg_wr_req = 1; bus.dbg_wr_addr = 13'h033; bus.dbg_wr_data = 16'h9999;
        #1;
        chk("rw_same_gnt", {bus.cpu_rd_gnt, bus.dbg_wr_gnt}, 2'b11);
        @(negedge clk);
        bus.dbg_wr_req = 0;
        #1;
        chk("rw_same_old", {bus.cpu_rvalid, bus.rdata}, {1'b1, 16'h1234});
        @(negedge clk);
        bus.cpu_rd_req = 0;
        #1;
        chk("rw_same_new", bus.rdata, 16'h9999);

        // window entry: cpu read granted as copy_req rises
        @(negedge clk);
        idle();
        bus.copy_req = 1;
        bus.cpu_rd_req = 1; bus.cpu_rd_addr = 13'h005;
        #1;
        chk("entry_gnt", {bus.cpu_rd_gnt, bus.copy_active}, 2'b10);
        chk("entry_addr", bus.mem_rd_addr, 13'h005);
        @(negedge clk);   // DRAIN
        bus.cpu_rd_req = 0;
        bus.dbg_rd_req = 1; bus.dbg_rd_addr = 13'h0AA;
        #1;
        chk("drain_rv", {bus.cpu_rvalid, bus.rdata}, {1'b1, 16'hC005});
        chk("drain_nognt", {bus.dbg_rd_gnt, bus.copy_active}, 2'b00);

        // window body
        @(negedge clk);   // COPY
        bus.rc_rd_req = 1; bus.rc_rd_addr = 13'h100;
        bus.bc_we = 1; bus.bc_addr = 13'h1F0; bus.bc_data = 16'hABCD;
        bus.cpu_wr_req = 1; bus.cpu_wr_addr = 13'h044; bus.cpu_wr_data = 16'h7777;
        #1;
        chk("copy_active", bus.copy_active, 1);
        chk("copy_rc_addr", bus.mem_rd_addr, 13'h100);
        chk("copy_bc_wr", {bus.mem_we, bus.mem_wr_addr, bus.mem_wr_data}, {1'b1, 13'h1F0, 16'hABCD});
        chk("copy_hold", {bus.cpu_wr_gnt, bus.dbg_rd_gnt}, 2'b00);
        @(negedge clk);   // COPY, last cycle
        bus.rc_rd_addr = 13'h101;
        bus.bc_we = 0;
        bus.copy_req = 0;
        #1;
        chk("copy_rc_rv", {bus.rc_rvalid, bus.rdata}, {1'b1, 16'hC100});
        chk("copy_hold2", {bus.mem_we, bus.cpu_wr_gnt, bus.copy_active}, 3'b001);

        // window exit
        @(negedge clk);   // RELEASE
        bus.rc_rd_req = 0;
        bus.copy_req = 1;
        #1;
        chk("rel_rc_rv", {bus.rc_rvalid, bus.rdata}, {1'b1, 16'hC101});
        chk("rel_nognt", {bus.copy_active, bus.cpu_wr_gnt, bus.dbg_rd_gnt}, 0);
        @(negedge clk);   // RUN despite copy_req
        #1;
        chk("post_gnt", {bus.copy_active, bus.cpu_wr_gnt, bus.dbg_rd_gnt, bus.rc_rvalid}, 4'b0110);
        chk("post_addr", {bus.mem_rd_addr, bus.mem_wr_addr}, {13'h0AA, 13'h044});
        @(negedge clk);   // DRAIN again
        idle();
        #1;
        chk("post_drain_rv", {bus.dbg_rvalid, bus.rdata}, {1'b1, 16'hC0AA});

        // read back the bc write, then bc drops in RUN
        @(negedge clk);
        bus.cpu_rd_req = 1; bus.cpu_rd_addr = 13'h1F0;
        #1;
        chk("rb_gnt", bus.cpu_rd_gnt, 1);
        @(negedge clk);
        bus.cpu_rd_req = 0;
        bus.bc_we = 1; bus.bc_addr = 13'h1F1; bus.bc_data = 16'h5555;
        #1;
        chk("rb_bc_data", bus.rdata, 16'hABCD);
        chk("drop1_we", bus.mem_we, 0);
        @(negedge clk); bus.bc_we = 0;
        @(negedge clk); bus.bc_we = 1;
        #1;
        chk("drop2_we", bus.mem_we, 0);
        @(negedge clk); bus.bc_we = 0;
        @(negedge clk); bus.bc_we = 1;
        @(negedge clk); bus.bc_we = 0;
        #1;
        chk("drop_cnt_3", bus.drop_cnt, 3);
        chk("conflict_keep", bus.conflict_cnt, 8);

        // saturation on the 4-bit instance
        @(negedge clk);
        sbus.cpu_rd_req = 1;
        sbus.dbg_rd_req = 1;
        repeat (10) @(negedge clk);
        #1;
        chk("sat_10", sbus.conflict_cnt, 10);
        repeat (10) @(negedge clk);
        #1;
        chk("sat_20", sbus.conflict_cnt, 15);
        repeat (5) @(negedge clk);
        #1;
        chk("sat_hold", sbus.conflict_cnt, 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
